// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the processing-element family.
// Combinational only; no latency and no backpressure.
package pe_pkg;

    localparam int SAT_W = 64;

    typedef logic signed [SAT_W-1:0] wide_t;

    typedef struct packed {
        logic  sat;
        wide_t sum;
    } sat_res_t;

    typedef enum logic {
        NO_WEIGHT = 1'b0,
        ARMED     = 1'b1
    } wstate_e;

    function automatic int pe_lat(input int mul_pipe);
        return 1 + mul_pipe;
    endfunction

    function automatic wide_t acc_max(input int bits);
        return (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t acc_min(input int bits);
        return -(wide_t'(1) <<< (bits - 1));
    endfunction

    // Operands arrive already sign-extended; result range is clamped to a bits-wide signed value.
    function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int bits,
                                         input logic clamp_en);
        sat_res_t r;
        wide_t    s;
        s     = a + b;
        r.sat = 1'b0;
        r.sum = s;
        if (clamp_en) begin
            if (s > acc_max(bits)) begin
                r.sum = acc_max(bits);
                r.sat = 1'b1;
            end else if (s < acc_min(bits)) begin
                r.sum = acc_min(bits);
                r.sat = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_sat_adder.sv
// Sign-extending adder with signed clamp to ACC_BITS; combinational, zero latency.
// No backpressure; sat_o only asserts when clamping is enabled and taken.
module pe_sat_adder
    import pe_pkg::*;
#(
    parameter int ACC_BITS  = 20,
    parameter int PROD_BITS = 16
) (
    input  logic signed [PROD_BITS-1:0] prod_i,
    input  logic signed [ACC_BITS-1:0]  psum_i,
    input  logic                        sat_en_i,
    output logic signed [ACC_BITS-1:0]  sum_o,
    output logic                        sat_o
);

    sat_res_t res;
    logic     unused_hi;

    // Sign extension to the wide helper type keeps the ACC_BITS+1 sum exact before clamping.
    always_comb begin
        res = sat_add(wide_t'(prod_i), wide_t'(psum_i), ACC_BITS, sat_en_i);
    end

    assign sum_o     = res.sum[ACC_BITS-1:0];
    assign sat_o     = res.sat;
    assign unused_hi = ^res.sum[SAT_W-1:ACC_BITS];

endmodule

// File: rtl/pe_mac_pipe.sv
// Weight-stationary MAC PE: psum + act*weight, saturated; latency LAT = 1 + MUL_PIPE.
// No backpressure: en low freezes every register, including weight chain and sat flag.
module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int ELEMENT_BITS = 8,
    parameter int ACC_BITS     = 20,
    parameter int MUL_PIPE     = 1
) (
    input  logic                    pe_clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    weight_load,
    input  logic [ELEMENT_BITS-1:0] weight_in,
    output logic [ELEMENT_BITS-1:0] weight_out,
    input  logic                    in_valid,
    input  logic [ELEMENT_BITS-1:0] input_next_pe,
    input  logic [ACC_BITS-1:0]     input_last_pe,
    output logic [ELEMENT_BITS-1:0] output_last_pe,
    output logic [ACC_BITS-1:0]     output_next_pe,
    output logic                    out_valid,
    input  logic                    clr_flags,
    output logic                    sat_flag
);

    localparam int LAT       = pe_lat(MUL_PIPE);
    localparam int PROD_BITS = 2 * ELEMENT_BITS;

    wstate_e                 wstate_q, wstate_d;
    logic [ELEMENT_BITS-1:0] weight_q, weight_d;

    always_ff @(posedge pe_clk or posedge reset) begin
        if (reset) begin
            wstate_q <= NO_WEIGHT;
            weight_q <= '0;
        end else begin
            wstate_q <= wstate_d;
            weight_q <= weight_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        weight_d = weight_q;
        if (en && weight_load) begin
            wstate_d = ARMED;
            weight_d = weight_in;
        end
    end

    assign weight_out = weight_q;

    // Uses the pre-load weight, so a sample arriving with weight_load sees the old value.
    // Invalid samples also get a zero product, which lets psum pass through untouched.
    logic signed [PROD_BITS-1:0] prod_c;

    always_comb begin
        prod_c = '0;
        if (wstate_q == ARMED && in_valid) begin
            prod_c = PROD_BITS'($signed(input_next_pe)) * PROD_BITS'($signed(weight_q));
        end
    end

    logic signed [PROD_BITS-1:0] add_prod;
    logic signed [ACC_BITS-1:0]  add_psum;
    logic [ELEMENT_BITS-1:0]     add_act;
    logic                        add_vld;

    generate
        if (LAT == 2) begin : g_mul_pipe
            logic [PROD_BITS-1:0]    s1_prod_q;
            logic [ACC_BITS-1:0]     s1_psum_q;
            logic [ELEMENT_BITS-1:0] s1_act_q;
            logic                    s1_vld_q;

            always_ff @(posedge pe_clk or posedge reset) begin
                if (reset) begin
                    s1_prod_q <= '0;
                    s1_psum_q <= '0;
                    s1_act_q  <= '0;
                    s1_vld_q  <= 1'b0;
                end else if (en) begin
                    s1_prod_q <= prod_c;
                    s1_psum_q <= input_last_pe;
                    s1_act_q  <= input_next_pe;
                    s1_vld_q  <= in_valid;
                end
            end

            assign add_prod = s1_prod_q;
            assign add_psum = s1_psum_q;
            assign add_act  = s1_act_q;
            assign add_vld  = s1_vld_q;
        end else begin : g_no_pipe
            assign add_prod = prod_c;
            assign add_psum = input_last_pe;
            assign add_act  = input_next_pe;
            assign add_vld  = in_valid;
        end
    endgenerate

    logic signed [ACC_BITS-1:0] sum_c;
    logic                       sat_c;

    pe_sat_adder #(
        .ACC_BITS (ACC_BITS),
        .PROD_BITS(PROD_BITS)
    ) u_sat_adder (
        .prod_i  (add_prod),
        .psum_i  (add_psum),
        .sat_en_i(add_vld),
        .sum_o   (sum_c),
        .sat_o   (sat_c)
    );

    logic [ELEMENT_BITS-1:0] act_q;
    logic [ACC_BITS-1:0]     sum_q;
    logic                    vld_q;
    logic                    sat_q, sat_d;

    // A clamp in the same cycle as clr_flags keeps the flag set.
    always_comb begin
        sat_d = sat_q;
        if (sat_c) begin
            sat_d = 1'b1;
        end else if (clr_flags) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge pe_clk or posedge reset) begin
        if (reset) begin
            act_q <= '0;
            sum_q <= '0;
            vld_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (en) begin
            act_q <= add_act;
            sum_q <= sum_c;
            vld_q <= add_vld;
            sat_q <= sat_d;
        end
    end

    assign output_last_pe = act_q;
    assign output_next_pe = sum_q;
    assign out_valid      = vld_q;
    assign sat_flag       = sat_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Bench for pe_mac_pipe: both pipeline depths side by side plus a 4-PE weight chain,
// checked against a sample-history reference model.
module tb_pe_mac_pipe;

    localparam int EB      = 8;
    localparam int AB      = 16;
    localparam int CAB     = 20;
    localparam int ACC_MAX = 32767;
    localparam int ACC_MIN = -32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           en = 1'b0, wload = 1'b0, vld = 1'b0, clr = 1'b0;
    logic [EB-1:0]  w_in = '0, act = '0;
    logic [AB-1:0]  psum = '0;
    logic [CAB-1:0] cpsum;

    assign cpsum = CAB'($signed(psum));

    logic [EB-1:0] wout  [2];
    logic [EB-1:0] act_o [2];
    logic [AB-1:0] sum_o [2];
    logic          vld_o [2];
    logic          sat_o [2];

    pe_mac_pipe #(.ELEMENT_BITS(EB), .ACC_BITS(AB), .MUL_PIPE(0)) dut0 (
        .pe_clk(clk), .reset(rst), .en(en), .weight_load(wload), .weight_in(w_in),
        .weight_out(wout[0]), .in_valid(vld), .input_next_pe(act), .input_last_pe(psum),
        .output_last_pe(act_o[0]), .output_next_pe(sum_o[0]), .out_valid(vld_o[0]),
        .clr_flags(clr), .sat_flag(sat_o[0])
    );

    pe_mac_pipe #(.ELEMENT_BITS(EB), .ACC_BITS(AB), .MUL_PIPE(1)) dut1 (
        .pe_clk(clk), .reset(rst), .en(en), .weight_load(wload), .weight_in(w_in),
        .weight_out(wout[1]), .in_valid(vld), .input_next_pe(act), .input_last_pe(psum),
        .output_last_pe(act_o[1]), .output_next_pe(sum_o[1]), .out_valid(vld_o[1]),
        .clr_flags(clr), .sat_flag(sat_o[1])
    );

    logic [EB-1:0]  cw    [5];
    logic [EB-1:0]  c_act [4];
    logic [CAB-1:0] c_sum [4];
    logic           c_vld [4];
    logic           c_sat [4];

    assign cw[0] = w_in;

    for (genvar g = 0; g < 4; g++) begin : g_chain
        pe_mac_pipe #(.ELEMENT_BITS(EB)) u_pe (
            .pe_clk(clk), .reset(rst), .en(en), .weight_load(wload), .weight_in(cw[g]),
            .weight_out(cw[g+1]), .in_valid(vld), .input_next_pe(act), .input_last_pe(cpsum),
            .output_last_pe(c_act[g]), .output_next_pe(c_sum[g]), .out_valid(c_vld[g]),
            .clr_flags(clr), .sat_flag(c_sat[g])
        );
    end

    typedef struct {
        bit vld;
        int act;
        int sum;
        bit sat;
    } samp_t;

    samp_t hist[$];
    int    w_m;
    bit    armed_m;
    bit    flag_m [2];
    int    cw_m   [4];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected output of a PE with latency L after n accepted cycles is the (n-L)-th sample.
    task automatic check_outputs();
        int    idx;
        samp_t ex;
        for (int d = 0; d < 2; d++) begin
            idx = hist.size() - (1 + d);
            ex  = '{0, 0, 0, 0};
            if (idx >= 0) ex = hist[idx];
            check($sformatf("d%0d.out_valid", d), vld_o[d], ex.vld);
            check($sformatf("d%0d.act_out", d), $signed(act_o[d]), ex.act);
            check($sformatf("d%0d.psum_out", d), $signed(sum_o[d]), ex.sum);
            check($sformatf("d%0d.sat_flag", d), sat_o[d], flag_m[d]);
            check($sformatf("d%0d.weight_out", d), $signed(wout[d]), w_m);
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("chain%0d.weight_out", g), $signed(cw[g+1]), cw_m[g]);
        end
    endtask

    task automatic step(input bit e, input bit wl, input int wi, input bit v,
                        input int a, input int p, input bit c);
        samp_t s;
        int    idx;
        en    = e;
        wload = wl;
        w_in  = EB'(wi);
        vld   = v;
        act   = EB'(a);
        psum  = AB'(p);
        clr   = c;
        @(posedge clk);
        #1;
        if (e) begin
            s = '{v, a, p, 0};
            if (v) begin
                s.sum = (armed_m ? a * w_m : 0) + p;
                if (s.sum > ACC_MAX) begin
                    s.sum = ACC_MAX;
                    s.sat = 1;
                end else if (s.sum < ACC_MIN) begin
                    s.sum = ACC_MIN;
                    s.sat = 1;
                end
            end
            hist.push_back(s);
            if (wl) begin
                w_m     = wi;
                armed_m = 1;
                for (int i = 3; i > 0; i--) cw_m[i] = cw_m[i-1];
                cw_m[0] = wi;
            end
            for (int d = 0; d < 2; d++) begin
                idx = hist.size() - (1 + d);
                if (idx >= 0 && hist[idx].sat) flag_m[d] = 1;
                else if (c) flag_m[d] = 0;
            end
        end
        check_outputs();
    endtask

    task automatic do_reset();
        en    = 1'b0;
        wload = 1'b0;
        vld   = 1'b0;
        clr   = 1'b0;
        rst   = 1'b1;
        #2;
        hist.delete();
        w_m     = 0;
        armed_m = 0;
        flag_m  = '{0, 0};
        for (int i = 0; i < 4; i++) cw_m[i] = 0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One valid sample then one idle cycle, checking spec-given literals at each PE's latency.
    task automatic directed(input string tag, input bit wl, input int wi, input int a,
                            input int p, input int exp_sum, input bit exp_sat);
        step(1, wl, wi, 1, a, p, 0);
        check({tag, ".lat1.valid"}, vld_o[0], 1);
        check({tag, ".lat1.psum"}, $signed(sum_o[0]), exp_sum);
        check({tag, ".lat1.act"}, $signed(act_o[0]), a);
        check({tag, ".lat2.early_valid"}, vld_o[1], 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check({tag, ".lat2.valid"}, vld_o[1], 1);
        check({tag, ".lat2.psum"}, $signed(sum_o[1]), exp_sum);
        check({tag, ".lat2.act"}, $signed(act_o[1]), a);
        if (exp_sat) begin
            check({tag, ".lat1.sat"}, sat_o[0], 1);
            check({tag, ".lat2.sat"}, sat_o[1], 1);
        end
    endtask

    bit re, rl, rv, rc;
    int rw, ra, rp;

    initial begin
        do_reset();

        directed("noweight", 0, 0, 7, -42, -42, 0);

        step(1, 1, 3, 0, 0, 0, 0);
        directed("load3", 0, 0, -5, 100, 85, 0);

        step(1, 1, 127, 0, 0, 0, 0);
        directed("satpos", 0, 0, 127, 32767, 32767, 1);
        directed("satneg", 0, 0, -128, -32768, -32768, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        check("clr.lat1.sat", sat_o[0], 0);
        check("clr.lat2.sat", sat_o[1], 0);

        step(1, 1, 2, 0, 0, 0, 0);
        directed("simul_old", 1, 10, 4, 0, 8, 0);
        directed("simul_new", 0, 0, 4, 0, 40, 0);

        step(1, 0, 0, 1, 11, 1000, 0);
        step(1, 0, 0, 1, -12, -2000, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 99, 1, 55, 5, 1);
        step(1, 0, 0, 1, 13, 3000, 0);
        step(1, 0, 0, 1, -14, -4000, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("stall.weight_out", $signed(wout[0]), 10);

        step(1, 0, 0, 1, 20, 20, 0);
        step(1, 0, 0, 1, 21, 21, 0);
        do_reset();
        step(1, 0, 0, 1, 50, 600, 0);
        check("rst.no_weight", $signed(sum_o[0]), 600);
        step(1, 0, 0, 0, 0, 0, 0);

        step(1, 1, $urandom_range(0, 255) - 128, 0, 0, 0, 0);
        for (int k = 0; k < 1000; k++) begin
            re = ($urandom_range(0, 7) != 0);
            rl = ($urandom_range(0, 15) == 0);
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 15) == 0);
            rw = $urandom_range(0, 255) - 128;
            ra = $urandom_range(0, 255) - 128;
            rp = $urandom_range(0, 65535) - 32768;
            step(re, rl, rw, rv, ra, rp, rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
